// File: rtl/jam_sweep_ctrl.sv
// jam_sweep_ctrl
//   Sequencer for the job-assignment DP engine.
//   A start request walks the controller through four phases:
//     LOAD  - streams every {worker, job} address to the cost ROM and writes the
//             returned words into the engine's cost table.
//     DRAIN - waits out the ROM latency so the final table write lands.
//     SWEEP - issues one relax command per (mask, free job) pair, in ascending
//             mask order, over a valid/ready port.
//     FLUSH - lets the engine pipeline empty, then strobes fin_valid/done.
//   No cost or dp storage is held here.
//
// Ports
//   CLK, RST      clock (rising edge) and asynchronous active-high reset
//   start         launch request, only looked at while idle
//   busy          high while a job is in flight; low again in the done cycle
//   done          one-cycle completion pulse, coincident with fin_valid
//   W, J          cost ROM worker / job address
//   Cost          cost ROM data, valid ROM_LAT cycles after W/J
//   ct_we         cost table write enable
//   ct_addr       cost table address ({W,J} delayed by ROM_LAT)
//   ct_wdata      cost table write data (Cost while ct_we is high)
//   relax_valid   relax command valid
//   relax_ready   engine accepts the relax command
//   relax_mask    assigned-job mask of the current command
//   relax_job     job being added (always a clear bit of relax_mask)
//   relax_worker  popcount(relax_mask): worker that receives relax_job
//   fin_valid     one-cycle strobe: dp[all ones] is final
module jam_sweep_ctrl #(
  parameter int N         = 8,
  parameter int COST_W    = 7,
  parameter int ROM_LAT   = 1,
  parameter int FLUSH_CYC = 4,
  localparam int LOGN     = $clog2(N)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [LOGN-1:0]   W,
  output logic [LOGN-1:0]   J,
  input  logic [COST_W-1:0] Cost,
  output logic              ct_we,
  output logic [2*LOGN-1:0] ct_addr,
  output logic [COST_W-1:0] ct_wdata,
  output logic              relax_valid,
  input  logic              relax_ready,
  output logic [N-1:0]      relax_mask,
  output logic [LOGN-1:0]   relax_job,
  output logic [LOGN-1:0]   relax_worker,
  output logic              fin_valid
);

  localparam int AW      = 2 * LOGN;
  localparam int CNT_MAX = (ROM_LAT > FLUSH_CYC) ? ROM_LAT : FLUSH_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [N-1:0]     LAST_MASK = {{(N-1){1'b1}}, 1'b0};
  localparam logic [AW-1:0]    LAST_ADDR = '1;
  localparam logic [CNT_W-1:0] DRAIN_END = CNT_W'(ROM_LAT - 1);
  localparam logic [CNT_W-1:0] FLUSH_END = CNT_W'(FLUSH_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_SWEEP,
    S_FLUSH
  } state_t;

  state_t state;
  state_t state_nxt;

  // ROM address counter; its natural wrap returns W/J to 0 after the last address
  logic [AW-1:0]    addr;
  // shared phase counter for DRAIN and FLUSH
  logic [CNT_W-1:0] cnt;
  logic [N-1:0]     mask;
  logic [LOGN-1:0]  job;

  // write-enable / address delay line matching the ROM latency
  logic [ROM_LAT-1:0] we_sr;
  logic [AW-1:0]      addr_sr [ROM_LAT];

  logic             hs;
  logic             next_found;
  logic [LOGN-1:0]  next_idx;
  logic [N-1:0]     mask_inc;
  logic [LOGN-1:0]  low_idx;
  logic             last_cmd;

  // ---------------------------------------------------------------------------
  // Free-job search
  //   next_idx : lowest clear bit of mask strictly above job
  //   low_idx  : lowest clear bit of mask+1 (first job of the next mask)
  // ---------------------------------------------------------------------------
  always_comb begin
    next_found = 1'b0;
    next_idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!next_found && !mask[i] && (i > 32'(job))) begin
        next_found = 1'b1;
        next_idx   = LOGN'(i);
      end
    end
  end

  assign mask_inc = mask + N'(1);

  always_comb begin
    logic found;
    found   = 1'b0;
    low_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && !mask_inc[i]) begin
        found   = 1'b1;
        low_idx = LOGN'(i);
      end
    end
  end

  // mask 2^N-2 has only bit 0 clear, so its single command is the final one
  assign last_cmd = (mask == LAST_MASK) && !next_found;
  assign hs       = relax_valid && relax_ready;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    busy        = 1'b0;
    done        = 1'b0;
    fin_valid   = 1'b0;
    relax_valid = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        busy = 1'b1;
        if (addr == LAST_ADDR) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (cnt == DRAIN_END) state_nxt = S_SWEEP;
      end
      S_SWEEP: begin
        busy        = 1'b1;
        relax_valid = 1'b1;
        if (relax_ready && last_cmd) state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        if (cnt == FLUSH_END) begin
          done      = 1'b1;
          fin_valid = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          busy = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      addr  <= '0;
      cnt   <= '0;
      mask  <= '0;
      job   <= '0;
      we_sr <= '0;
      for (int unsigned i = 0; i < ROM_LAT; i++) begin
        addr_sr[i] <= '0;
      end
    end else begin
      we_sr[0]   <= (state == S_LOAD);
      addr_sr[0] <= addr;
      for (int unsigned i = 1; i < ROM_LAT; i++) begin
        we_sr[i]   <= we_sr[i-1];
        addr_sr[i] <= addr_sr[i-1];
      end

      unique case (state)
        S_LOAD: begin
          addr <= addr + AW'(1);
          cnt  <= '0;
        end
        S_DRAIN: begin
          cnt <= (cnt == DRAIN_END) ? '0 : cnt + CNT_W'(1);
        end
        S_SWEEP: begin
          cnt <= '0;
          if (hs) begin
            if (last_cmd) begin
              // park mask/job at 0 so the command outputs idle low
              mask <= '0;
              job  <= '0;
            end else if (next_found) begin
              job <= next_idx;
            end else begin
              mask <= mask_inc;
              job  <= low_idx;
            end
          end
        end
        S_FLUSH: begin
          cnt <= (cnt == FLUSH_END) ? '0 : cnt + CNT_W'(1);
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign W            = addr[AW-1:LOGN];
  assign J            = addr[LOGN-1:0];
  assign ct_we        = we_sr[ROM_LAT-1];
  assign ct_addr      = addr_sr[ROM_LAT-1];
  // gated so the table port idles at 0 outside the write window
  assign ct_wdata     = ct_we ? Cost : '0;
  assign relax_mask   = mask;
  assign relax_job    = job;
  assign relax_worker = LOGN'($countones(mask));

endmodule

// File: tb/tb_jam_sweep_ctrl.sv
// tb_jam_sweep_ctrl
//   Directed self-checking bench for jam_sweep_ctrl with a 1-cycle ROM model
//   returning Cost = {W,J}. Outputs are sampled on the falling clock edge;
//   inputs are driven there too, so they are stable at the next rising edge.
module tb_jam_sweep_ctrl;

  localparam int N         = 8;
  localparam int LOGN      = 3;
  localparam int COST_W    = 7;
  localparam int ROM_LAT   = 1;
  localparam int FLUSH_CYC = 4;
  localparam int NCMD      = N * (1 << (N - 1));  // 1024
  // LOAD entry is cycle 0; LOAD 64 + DRAIN 1 + SWEEP 1024 + FLUSH 4 cycles,
  // done sits in the last FLUSH cycle: the 1093rd cycle, index 1092
  localparam int DONE_CYC  = N * N + ROM_LAT + NCMD + FLUSH_CYC - 1;
  localparam int BOUND     = 4000;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              start = 1'b0;
  logic              relax_ready = 1'b0;
  logic [COST_W-1:0] Cost = '0;
  logic              busy, done, ct_we, relax_valid, fin_valid;
  logic [LOGN-1:0]   W, J, relax_job, relax_worker;
  logic [2*LOGN-1:0] ct_addr;
  logic [COST_W-1:0] ct_wdata;
  logic [N-1:0]      relax_mask;

  int total = 0;
  int bad   = 0;

  logic [N-1:0]    exp_mask [NCMD];
  logic [LOGN-1:0] exp_job  [NCMD];

  jam_sweep_ctrl #(
    .N(N),
    .COST_W(COST_W),
    .ROM_LAT(ROM_LAT),
    .FLUSH_CYC(FLUSH_CYC)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .start(start),
    .busy(busy),
    .done(done),
    .W(W),
    .J(J),
    .Cost(Cost),
    .ct_we(ct_we),
    .ct_addr(ct_addr),
    .ct_wdata(ct_wdata),
    .relax_valid(relax_valid),
    .relax_ready(relax_ready),
    .relax_mask(relax_mask),
    .relax_job(relax_job),
    .relax_worker(relax_worker),
    .fin_valid(fin_valid)
  );

  always #5 CLK = ~CLK;

  // cost ROM model, 1-cycle latency
  always @(posedge CLK) Cost <= {1'b0, W, J};

  // reference command order: every mask below all-ones, every clear job in it
  task automatic build_expected;
    int idx;
    logic [N-1:0] m;
    idx = 0;
    for (int mi = 0; mi < (1 << N) - 1; mi++) begin
      m = N'(mi);
      for (int j = 0; j < N; j++) begin
        if (!m[j]) begin
          exp_mask[idx] = m;
          exp_job[idx]  = LOGN'(j);
          idx++;
        end
      end
    end
  endtask

  // returns at the falling edge of the LOAD entry cycle
  task automatic launch;
    @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic test_reset;
    RST = 1'b1;
    start = 1'b0;
    relax_ready = 1'b0;
    repeat (2) @(negedge CLK);
    total++;
    if ({busy, done, fin_valid, ct_we, relax_valid, W, J, ct_addr, ct_wdata,
         relax_mask, relax_job, relax_worker} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b we=%b valid=%b W=%0d J=%0d addr=%0d mask=%h expected all 0",
               busy, done, ct_we, relax_valid, W, J, ct_addr, relax_mask);
    end
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle_busy: got %b expected 0", busy);
    end
    total++;
    if (relax_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle_valid: got %b expected 0", relax_valid);
    end
  endtask

  task automatic test_load;
    int n_we;
    bit seen;
    relax_ready = 1'b1;
    launch();
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL load_busy_entry: got %b expected 1", busy);
    end
    n_we = 0;
    seen = 0;
    for (int c = 0; c < BOUND && !seen; c++) begin
      if (ct_we) begin
        total++;
        if (c !== n_we + ROM_LAT) begin
          bad++;
          $display("FAIL load_we_cycle: write %0d at cycle %0d expected cycle %0d", n_we, c, n_we + ROM_LAT);
        end
        total++;
        if (ct_addr !== (2*LOGN)'(n_we)) begin
          bad++;
          $display("FAIL load_addr: got %0d expected %0d", ct_addr, n_we);
        end
        total++;
        if (ct_wdata !== COST_W'(n_we)) begin
          bad++;
          $display("FAIL load_wdata: got %0d expected %0d", ct_wdata, n_we);
        end
        n_we++;
      end
      if (done) seen = 1;
      else @(negedge CLK);
    end
    total++;
    if (n_we !== N * N) begin
      bad++;
      $display("FAIL load_we_count: got %0d expected %0d", n_we, N * N);
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL load_done_timeout: got no done expected done within %0d cycles", BOUND);
    end
  endtask

  task automatic test_order_latency;
    int h, done_cyc;
    bit seen, busy_prev, busy_done;
    logic [N-1:0]    m0, m8, ml;
    logic [LOGN-1:0] j0, j7, j8, jl, w0, w8, wl;
    relax_ready = 1'b1;
    launch();
    h = 0;
    seen = 0;
    done_cyc = -1;
    busy_prev = 0;
    busy_done = 1;
    for (int c = 0; c < BOUND && !seen; c++) begin
      total++;
      if (fin_valid !== done) begin
        bad++;
        $display("FAIL order_fin_vs_done: cycle %0d fin_valid=%b expected done=%b", c, fin_valid, done);
      end
      if (relax_valid) begin
        if (h < NCMD) begin
          total++;
          if (relax_mask !== exp_mask[h] || relax_job !== exp_job[h] ||
              relax_worker !== LOGN'($countones(exp_mask[h]))) begin
            bad++;
            $display("FAIL order_cmd: #%0d got mask=%h job=%0d worker=%0d expected mask=%h job=%0d worker=%0d",
                     h, relax_mask, relax_job, relax_worker, exp_mask[h], exp_job[h], $countones(exp_mask[h]));
          end
        end
        if (h == 0) begin m0 = relax_mask; j0 = relax_job; w0 = relax_worker; end
        if (h == 7) j7 = relax_job;
        if (h == 8) begin m8 = relax_mask; j8 = relax_job; w8 = relax_worker; end
        ml = relax_mask; jl = relax_job; wl = relax_worker;
        h++;
      end
      if (done) begin
        seen = 1;
        done_cyc = c;
        busy_done = busy;
      end else begin
        busy_prev = busy;
        @(negedge CLK);
      end
    end
    total++;
    if (h !== NCMD) begin
      bad++;
      $display("FAIL order_count: got %0d expected %0d", h, NCMD);
    end
    total++;
    if (done_cyc !== DONE_CYC) begin
      bad++;
      $display("FAIL order_latency: got %0d expected %0d", done_cyc, DONE_CYC);
    end
    total++;
    if (busy_done !== 1'b0 || busy_prev !== 1'b1) begin
      bad++;
      $display("FAIL order_busy_fall: got before=%b at_done=%b expected 1 0", busy_prev, busy_done);
    end
    total++;
    if ({m0, j0, w0} !== {8'h00, 3'd0, 3'd0}) begin
      bad++;
      $display("FAIL order_first: got mask=%h job=%0d worker=%0d expected 00 0 0", m0, j0, w0);
    end
    total++;
    if (j7 !== 3'd7) begin
      bad++;
      $display("FAIL order_eighth: got job=%0d expected 7", j7);
    end
    total++;
    if ({m8, j8, w8} !== {8'h01, 3'd1, 3'd1}) begin
      bad++;
      $display("FAIL order_ninth: got mask=%h job=%0d worker=%0d expected 01 1 1", m8, j8, w8);
    end
    total++;
    if ({ml, jl, wl} !== {8'hFE, 3'd0, 3'd7}) begin
      bad++;
      $display("FAIL order_last: got mask=%h job=%0d worker=%0d expected fe 0 7", ml, jl, wl);
    end
    @(negedge CLK);
    total++;
    if ({done, fin_valid, busy, relax_valid} !== 4'b0000) begin
      bad++;
      $display("FAIL order_after_done: got done=%b fin=%b busy=%b valid=%b expected 0000", done, fin_valid, busy, relax_valid);
    end
  endtask

  task automatic test_backpressure;
    int h, stalls, done_cyc;
    bit seen, hold, r;
    logic [N-1:0]    hm;
    logic [LOGN-1:0] hj, hw;
    launch();
    h = 0;
    stalls = 0;
    seen = 0;
    hold = 0;
    done_cyc = -1;
    for (int c = 0; c < BOUND && !seen; c++) begin
      r = 1'($urandom_range(0, 1));
      relax_ready = r;
      if (relax_valid) begin
        if (hold) begin
          total++;
          if ({relax_mask, relax_job, relax_worker} !== {hm, hj, hw}) begin
            bad++;
            $display("FAIL bp_stable: got mask=%h job=%0d worker=%0d expected mask=%h job=%0d worker=%0d",
                     relax_mask, relax_job, relax_worker, hm, hj, hw);
          end
        end
        if (r) begin
          if (h < NCMD) begin
            total++;
            if (relax_mask !== exp_mask[h] || relax_job !== exp_job[h]) begin
              bad++;
              $display("FAIL bp_order: #%0d got mask=%h job=%0d expected mask=%h job=%0d",
                       h, relax_mask, relax_job, exp_mask[h], exp_job[h]);
            end
          end
          h++;
          hold = 0;
        end else begin
          stalls++;
          hold = 1;
          hm = relax_mask; hj = relax_job; hw = relax_worker;
        end
      end else if (hold) begin
        total++;
        bad++;
        $display("FAIL bp_valid_drop: got valid=0 expected 1");
        hold = 0;
      end
      if (done) begin
        seen = 1;
        done_cyc = c;
      end else begin
        @(negedge CLK);
      end
    end
    relax_ready = 1'b1;
    total++;
    if (h !== NCMD) begin
      bad++;
      $display("FAIL bp_count: got %0d expected %0d", h, NCMD);
    end
    total++;
    if (done_cyc !== DONE_CYC + stalls) begin
      bad++;
      $display("FAIL bp_latency: got %0d expected %0d", done_cyc, DONE_CYC + stalls);
    end
  endtask

  task automatic test_reset_mid_sweep;
    bit found;
    int n_done;
    relax_ready = 1'b1;
    launch();
    found = 0;
    for (int c = 0; c < BOUND && !found; c++) begin
      if (relax_valid && relax_mask == 8'h37) found = 1;
      else @(negedge CLK);
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL rst_reach_mask: got no mask 37 expected mask 37 within %0d cycles", BOUND);
    end
    RST = 1'b1;
    @(negedge CLK);
    total++;
    if ({busy, done, fin_valid, ct_we, relax_valid, W, J, ct_addr, ct_wdata,
         relax_mask, relax_job, relax_worker} !== '0) begin
      bad++;
      $display("FAIL rst_mid_outputs: got busy=%b valid=%b mask=%h job=%0d worker=%0d expected all 0",
               busy, relax_valid, relax_mask, relax_job, relax_worker);
    end
    RST = 1'b0;
    n_done = 0;
    repeat (20) begin
      @(negedge CLK);
      if (done || fin_valid) n_done++;
    end
    total++;
    if (n_done !== 0) begin
      bad++;
      $display("FAIL rst_no_done: got %0d done cycles expected 0", n_done);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_idle: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_start_ignored;
    int n_done, done_cyc;
    relax_ready = 1'b1;
    launch();
    n_done = 0;
    done_cyc = -1;
    for (int c = 0; c < BOUND && n_done == 0; c++) begin
      start = (c == 10 || c == 11 || c == 500 || c == 800);
      if (done) begin
        n_done++;
        done_cyc = c;
      end else begin
        @(negedge CLK);
      end
    end
    total++;
    if (done_cyc !== DONE_CYC) begin
      bad++;
      $display("FAIL start_ignored_latency: got %0d expected %0d", done_cyc, DONE_CYC);
    end
    // hold start through done: one idle cycle, then relaunch
    start = 1'b1;
    @(negedge CLK);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL start_hold_idle: got busy=%b expected 0", busy);
    end
    @(negedge CLK);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL start_hold_relaunch: got busy=%b expected 1", busy);
    end
    start = 1'b0;
    done_cyc = -1;
    for (int c = 0; c < BOUND && done_cyc < 0; c++) begin
      if (done) done_cyc = c;
      else @(negedge CLK);
    end
    total++;
    if (done_cyc !== DONE_CYC) begin
      bad++;
      $display("FAIL start_relaunch_latency: got %0d expected %0d", done_cyc, DONE_CYC);
    end
    n_done = 0;
    repeat (30) begin
      @(negedge CLK);
      if (done) n_done++;
    end
    total++;
    if (n_done !== 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL start_extra_done: got %0d extra done busy=%b expected 0 0", n_done, busy);
    end
  endtask

  initial begin
    build_expected();
    test_reset();
    test_load();
    test_order_latency();
    test_backpressure();
    test_reset_mid_sweep();
    test_load();
    test_order_latency();
    test_start_ignored();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
